// File: rtl/regbank_pkg.sv
// Shared constants and write-port arbitration for the register bank.
// The pipeline's fixed collision winner is WR_PRI below.
package regbank_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        WR_PRI_DS,
        WR_PRI_ES
    } wr_pri_t;

    // DecodeStage holds the younger instruction, so its data must win.
    localparam wr_pri_t WR_PRI = WR_PRI_DS;

    // Returns {commit_ds, commit_es} from the qualified enables and an address match.
    function automatic logic [1:0] wr_commit(input logic en_ds,
                                             input logic en_es,
                                             input logic same_addr);
        logic [1:0] c;
        c = {en_ds, en_es};
        if (en_ds && en_es && same_addr) begin
            c = (WR_PRI == WR_PRI_DS) ? 2'b10 : 2'b01;
        end
        return c;
    endfunction

endpackage

// File: rtl/regbank_if.sv
// Bus between DecodeStage/ExecuteStage (master) and the register bank (slave).
// Carries both read ports, both write ports, scoreboard set and the collision count.
interface regbank_if
    import regbank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_addr1_ds;
    logic [DATA_W-1:0] rd_data1_ds;
    logic [ADDR_W-1:0] rd_addr2_ds;
    logic [DATA_W-1:0] rd_data2_ds;
    logic              busy1_ds;
    logic              busy2_ds;
    logic              wr_en_ds;
    logic [ADDR_W-1:0] wr_addr_ds;
    logic [DATA_W-1:0] wr_data_ds;
    logic              wr_en_es;
    logic [ADDR_W-1:0] wr_addr_es;
    logic [DATA_W-1:0] wr_data_es;
    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_addr;
    logic [CNT_W-1:0]  collide_cnt;

    modport master (
        output rd_addr1_ds, rd_addr2_ds,
        output wr_en_ds, wr_addr_ds, wr_data_ds,
        output wr_en_es, wr_addr_es, wr_data_es,
        output sb_set_en, sb_set_addr,
        input  rd_data1_ds, rd_data2_ds, busy1_ds, busy2_ds, collide_cnt
    );

    modport slave (
        input  rd_addr1_ds, rd_addr2_ds,
        input  wr_en_ds, wr_addr_ds, wr_data_ds,
        input  wr_en_es, wr_addr_es, wr_data_es,
        input  sb_set_en, sb_set_addr,
        output rd_data1_ds, rd_data2_ds, busy1_ds, busy2_ds, collide_cnt
    );

endinterface

// File: rtl/regbank_scoreboard.sv
// Per-register pending vector with two combinational read taps.
// A set and a clear to the same register in one cycle leave it set.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              busy1,
    output logic              busy2
);
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pend;
        if (clr_en) pend_nxt[clr_addr] = 1'b0;
        if (set_en) pend_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    assign busy1 = pend[rd_addr1];
    assign busy2 = pend[rd_addr2];

endmodule

// File: rtl/regbank_sb.sv
// Register bank with two combinational reads, two clocked writes, pending scoreboard
// and saturating collision counter. Same-cycle read forwarding when REGBANK_BYPASS_EN is defined.
module regbank_sb
    import regbank_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 0,
    parameter  int CNT_W    = 8,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    regbank_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt;

    logic              ds_ok, es_ok, same_addr, collide;
    logic              commit_ds, commit_es;
    logic              set_ok;

    logic [ADDR_W-1:0] rd_addr  [2];
    logic [DATA_W-1:0] rd_data  [2];
    logic              busy_raw [2];
    logic              busy     [2];

    // Address 0 is dropped from every write path when it is hardwired to zero.
    assign ds_ok     = bus.wr_en_ds  && !(ZERO_REG != 0 && bus.wr_addr_ds  == '0);
    assign es_ok     = bus.wr_en_es  && !(ZERO_REG != 0 && bus.wr_addr_es  == '0);
    assign set_ok    = bus.sb_set_en && !(ZERO_REG != 0 && bus.sb_set_addr == '0);
    assign same_addr = (bus.wr_addr_ds == bus.wr_addr_es);
    assign collide   = ds_ok && es_ok && same_addr;
    assign {commit_ds, commit_es} = wr_commit(ds_ok, es_ok, same_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (commit_es) mem[bus.wr_addr_es] <= bus.wr_data_es;
            if (commit_ds) mem[bus.wr_addr_ds] <= bus.wr_data_ds;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (collide && cnt != '1) cnt <= cnt + 1'b1;
    end

    regbank_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_ok),
        .set_addr (bus.sb_set_addr),
        .clr_en   (bus.wr_en_es),
        .clr_addr (bus.wr_addr_es),
        .rd_addr1 (rd_addr[0]),
        .rd_addr2 (rd_addr[1]),
        .busy1    (busy_raw[0]),
        .busy2    (busy_raw[1])
    );

    assign rd_addr[0] = bus.rd_addr1_ds;
    assign rd_addr[1] = bus.rd_addr2_ds;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem[rd_addr[p]];
            busy[p]    = busy_raw[p];
`ifdef REGBANK_BYPASS_EN
            if (bus.wr_en_ds && bus.wr_addr_ds == rd_addr[p]) begin
                rd_data[p] = bus.wr_data_ds;
            end else if (bus.wr_en_es && bus.wr_addr_es == rd_addr[p]) begin
                rd_data[p] = bus.wr_data_es;
            end
            if (bus.wr_en_es && bus.wr_addr_es == rd_addr[p] &&
                !(bus.sb_set_en && bus.sb_set_addr == rd_addr[p])) begin
                busy[p] = 1'b0;
            end
`endif
            if (ZERO_REG != 0 && rd_addr[p] == '0) begin
                rd_data[p] = '0;
                busy[p]    = 1'b0;
            end
        end
    end

    assign bus.rd_data1_ds = rd_data[0];
    assign bus.rd_data2_ds = rd_data[1];
    assign bus.busy1_ds    = busy[0];
    assign bus.busy2_ds    = busy[1];
    assign bus.collide_cnt = cnt;

endmodule

// File: tb/tb_regbank_sb.sv
// Directed self-checking bench for regbank_sb: one default instance and one with ZERO_REG=1.
// Expectations follow REGBANK_BYPASS_EN where same-cycle visibility differs.
module tb_regbank_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regbank_if #(.DATA_W(32), .DEPTH(16), .CNT_W(8)) b  ();
    regbank_if #(.DATA_W(32), .DEPTH(16), .CNT_W(8)) bz ();

    regbank_sb #(.DATA_W(32), .DEPTH(16), .ZERO_REG(0), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    regbank_sb #(.DATA_W(32), .DEPTH(16), .ZERO_REG(1), .CNT_W(8)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_b();
        b.wr_en_ds = 1'b0; b.wr_addr_ds = '0; b.wr_data_ds = '0;
        b.wr_en_es = 1'b0; b.wr_addr_es = '0; b.wr_data_es = '0;
        b.sb_set_en = 1'b0; b.sb_set_addr = '0;
    endtask

    task automatic idle_bz();
        bz.wr_en_ds = 1'b0; bz.wr_addr_ds = '0; bz.wr_data_ds = '0;
        bz.wr_en_es = 1'b0; bz.wr_addr_es = '0; bz.wr_data_es = '0;
        bz.sb_set_en = 1'b0; bz.sb_set_addr = '0;
    endtask

    initial begin
        idle_b();
        idle_bz();
        b.rd_addr1_ds = '0;  b.rd_addr2_ds = '0;
        bz.rd_addr1_ds = '0; bz.rd_addr2_ds = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_rd1", b.rd_data1_ds, 32'h0);
        chk("rst_cnt", {24'h0, b.collide_cnt}, 32'h0);
        rst = 1'b0;
        tick();

        // Reset asserted mid-write discards the write
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd3; b.wr_data_ds = 32'hDEADBEEF;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_b();
        b.rd_addr1_ds = 4'd3;
        tick();
        chk("rstw_r3", b.rd_data1_ds, 32'h0);
        chk("rstw_busy", {31'h0, b.busy1_ds}, 32'h0);
        chk("rstw_cnt", {24'h0, b.collide_cnt}, 32'h0);

        // Dual write, distinct addresses
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd2; b.wr_data_ds = 32'h11;
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd5; b.wr_data_es = 32'h22;
        tick();
        idle_b();
        b.rd_addr1_ds = 4'd2; b.rd_addr2_ds = 4'd5;
        #1;
        chk("dual_r2", b.rd_data1_ds, 32'h11);
        chk("dual_r5", b.rd_data2_ds, 32'h22);
        chk("dual_cnt", {24'h0, b.collide_cnt}, 32'h0);

        // Same-address collision: DS data wins
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd7; b.wr_data_ds = 32'hAAAA;
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd7; b.wr_data_es = 32'h5555;
        tick();
        idle_b();
        b.rd_addr1_ds = 4'd7; b.rd_addr2_ds = 4'd7;
        #1;
        chk("col_r7_p1", b.rd_data1_ds, 32'hAAAA);
        chk("col_r7_p2", b.rd_data2_ds, 32'hAAAA);
        chk("col_cnt1", {24'h0, b.collide_cnt}, 32'h1);

        // Saturation: 254 more reach 255, 45 more hold it
        for (int i = 0; i < 254; i++) begin
            b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd7; b.wr_data_ds = 32'h1000 + i;
            b.wr_en_es = 1'b1; b.wr_addr_es = 4'd7; b.wr_data_es = 32'h2000 + i;
            tick();
        end
        idle_b();
        #1;
        chk("col_cnt255", {24'h0, b.collide_cnt}, 32'd255);
        for (int i = 0; i < 45; i++) begin
            b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd7; b.wr_data_ds = 32'h3000 + i;
            b.wr_en_es = 1'b1; b.wr_addr_es = 4'd7; b.wr_data_es = 32'h4000 + i;
            tick();
        end
        idle_b();
        #1;
        chk("col_sat", {24'h0, b.collide_cnt}, 32'd255);
        chk("col_last", b.rd_data1_ds, 32'h3000 + 44);

        // Scoreboard set
        b.sb_set_en = 1'b1; b.sb_set_addr = 4'd4;
        tick();
        idle_b();
        b.rd_addr1_ds = 4'd4;
        #1;
        chk("sb_set", {31'h0, b.busy1_ds}, 32'h1);

        // Set and clear together: stays pending
        b.sb_set_en = 1'b1; b.sb_set_addr = 4'd4;
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd4; b.wr_data_es = 32'h44;
        #1;
        chk("sb_setclr_now", {31'h0, b.busy1_ds}, 32'h1);
        tick();
        idle_b();
        #1;
        chk("sb_setclr", {31'h0, b.busy1_ds}, 32'h1);
        chk("sb_r4a", b.rd_data1_ds, 32'h44);

        // ES write alone clears
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd4; b.wr_data_es = 32'h45;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("sb_clr_now", {31'h0, b.busy1_ds}, 32'h0);
`else
        chk("sb_clr_now", {31'h0, b.busy1_ds}, 32'h1);
`endif
        tick();
        idle_b();
        #1;
        chk("sb_clr", {31'h0, b.busy1_ds}, 32'h0);
        chk("sb_r4b", b.rd_data1_ds, 32'h45);

        // Clearing a non-pending bit is a no-op
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd4; b.wr_data_es = 32'h46;
        tick();
        idle_b();
        #1;
        chk("sb_clr_idle", {31'h0, b.busy1_ds}, 32'h0);

        // Double set, DS write does not clear
        b.rd_addr2_ds = 4'd6;
        b.sb_set_en = 1'b1; b.sb_set_addr = 4'd6;
        tick();
        tick();
        idle_b();
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd6; b.wr_data_ds = 32'h66;
        tick();
        idle_b();
        #1;
        chk("sb_dbl_set", {31'h0, b.busy2_ds}, 32'h1);
        chk("sb_ds_keep_r6", b.rd_data2_ds, 32'h66);

        // ZERO_REG instance: r0 writes/sets dropped, not counted
        bz.rd_addr1_ds = 4'd0; bz.rd_addr2_ds = 4'd1;
        bz.wr_en_ds = 1'b1; bz.wr_addr_ds = 4'd0; bz.wr_data_ds = 32'h1234;
        bz.wr_en_es = 1'b1; bz.wr_addr_es = 4'd0; bz.wr_data_es = 32'h9999;
        bz.sb_set_en = 1'b1; bz.sb_set_addr = 4'd0;
        #1;
        chk("z_r0_now", bz.rd_data1_ds, 32'h0);
        tick();
        idle_bz();
        #1;
        chk("z_r0", bz.rd_data1_ds, 32'h0);
        chk("z_busy0", {31'h0, bz.busy1_ds}, 32'h0);
        chk("z_cnt0", {24'h0, bz.collide_cnt}, 32'h0);
        bz.wr_en_ds = 1'b1; bz.wr_addr_ds = 4'd1; bz.wr_data_ds = 32'h1234;
        bz.wr_en_es = 1'b1; bz.wr_addr_es = 4'd1; bz.wr_data_es = 32'h5678;
        tick();
        idle_bz();
        #1;
        chk("z_r1", bz.rd_data2_ds, 32'h1234);
        chk("z_cnt1", {24'h0, bz.collide_cnt}, 32'h1);

        // Bypass / write visibility
        b.rd_addr1_ds = 4'd9; b.rd_addr2_ds = 4'd10;
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd9; b.wr_data_ds = 32'h55;
        tick();
        idle_b();
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd9;  b.wr_data_ds = 32'h77;
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd10; b.wr_data_es = 32'h99;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("byp_r9_now", b.rd_data1_ds, 32'h77);
        chk("byp_r10_now", b.rd_data2_ds, 32'h99);
`else
        chk("byp_r9_now", b.rd_data1_ds, 32'h55);
        chk("byp_r10_now", b.rd_data2_ds, 32'h0);
`endif
        tick();
        idle_b();
        #1;
        chk("byp_r9_next", b.rd_data1_ds, 32'h77);
        chk("byp_r10_next", b.rd_data2_ds, 32'h99);

        // Both ports writing the read address: DS forwarded over ES
        b.wr_en_ds = 1'b1; b.wr_addr_ds = 4'd9; b.wr_data_ds = 32'h88;
        b.wr_en_es = 1'b1; b.wr_addr_es = 4'd9; b.wr_data_es = 32'hBB;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("byp_pri_now", b.rd_data1_ds, 32'h88);
`else
        chk("byp_pri_now", b.rd_data1_ds, 32'h77);
`endif
        tick();
        idle_b();
        #1;
        chk("byp_pri_next", b.rd_data1_ds, 32'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
